// File: rtl/ram_1r1w_rd_arbiter_if.sv
// ram_1r1w_rd_arbiter_if
//   Bundles every handshake/bus signal around the shared 1R1W RAM arbiter:
//   two read requesters (rd0/rd1), two write requesters (wr0/wr1) and the
//   RAM's read and write ports.
//   Modports:
//     slave  - arbiter view: requester requests and RAM responses/readys are
//              inputs; requester readys/responses and RAM requests are outputs.
//     master - environment view (requesters + RAM), the mirror of slave.
//   width_p/addr_w_p must match the arbiter instance they connect to.
interface ram_1r1w_rd_arbiter_if #(
  parameter int width_p  = 32,
  parameter int addr_w_p = 4
);
  // read requesters
  logic                rd0_req_val, rd1_req_val;
  logic [addr_w_p-1:0] rd0_req_addr, rd1_req_addr;
  logic                rd0_req_rdy, rd1_req_rdy;
  logic                rd0_resp_val, rd1_resp_val;
  logic [width_p-1:0]  rd0_resp_data, rd1_resp_data;
  logic                rd0_resp_rdy, rd1_resp_rdy;
  // write requesters
  logic                wr0_req_val, wr1_req_val;
  logic [addr_w_p-1:0] wr0_req_addr, wr1_req_addr;
  logic [width_p-1:0]  wr0_req_data, wr1_req_data;
  logic                wr0_req_rdy, wr1_req_rdy;
  // RAM write port
  logic                ram_wr_req_val;
  logic [addr_w_p-1:0] ram_wr_req_addr;
  logic [width_p-1:0]  ram_wr_req_data;
  logic                ram_wr_req_rdy;
  // RAM read port
  logic                ram_rd_req_val;
  logic [addr_w_p-1:0] ram_rd_req_addr;
  logic                ram_rd_req_rdy;
  logic                ram_rd_resp_val;
  logic [width_p-1:0]  ram_rd_resp_data;
  logic                ram_rd_resp_rdy;

  modport slave (
    input  rd0_req_val, rd1_req_val, rd0_req_addr, rd1_req_addr,
    output rd0_req_rdy, rd1_req_rdy,
    output rd0_resp_val, rd1_resp_val, rd0_resp_data, rd1_resp_data,
    input  rd0_resp_rdy, rd1_resp_rdy,
    input  wr0_req_val, wr1_req_val, wr0_req_addr, wr1_req_addr,
    input  wr0_req_data, wr1_req_data,
    output wr0_req_rdy, wr1_req_rdy,
    output ram_wr_req_val, ram_wr_req_addr, ram_wr_req_data,
    input  ram_wr_req_rdy,
    output ram_rd_req_val, ram_rd_req_addr,
    input  ram_rd_req_rdy,
    input  ram_rd_resp_val, ram_rd_resp_data,
    output ram_rd_resp_rdy
  );

  modport master (
    output rd0_req_val, rd1_req_val, rd0_req_addr, rd1_req_addr,
    input  rd0_req_rdy, rd1_req_rdy,
    input  rd0_resp_val, rd1_resp_val, rd0_resp_data, rd1_resp_data,
    output rd0_resp_rdy, rd1_resp_rdy,
    output wr0_req_val, wr1_req_val, wr0_req_addr, wr1_req_addr,
    output wr0_req_data, wr1_req_data,
    input  wr0_req_rdy, wr1_req_rdy,
    input  ram_wr_req_val, ram_wr_req_addr, ram_wr_req_data,
    output ram_wr_req_rdy,
    input  ram_rd_req_val, ram_rd_req_addr,
    output ram_rd_req_rdy,
    output ram_rd_resp_val, ram_rd_resp_data,
    input  ram_rd_resp_rdy
  );
endinterface

// File: rtl/ram_1r1w_rd_arbiter.sv
// ram_1r1w_rd_arbiter
//   Shares one synchronous 1R1W RAM (1-cycle read latency, one read in
//   flight, response backpressure) between two read and two write requesters
//   on the shared payload buffer (requester 0 = TCP engine, 1 = app/DMA).
//   Reads: round-robin; an owner bit remembers who issued the in-flight read
//   and steers the response back to it. Writes: fixed priority, wr0 wins.
//   Ports:
//     clk, rst       - clock, synchronous active-high reset
//     bus (slave)    - all requester and RAM handshake signals
//   Optional (macro RAM_RD_ARB_STATS_EN):
//     rd0_grant_cnt, rd1_grant_cnt - read handshakes per requester (wrapping)
//     rd_stall_cnt                 - cycles with a read pending but RAM busy
module ram_1r1w_rd_arbiter #(
  parameter int width_p  = 32,
  parameter int els_p    = 16,
  parameter int addr_w_p = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic clk,
  input  logic rst,
  ram_1r1w_rd_arbiter_if.slave bus
`ifdef RAM_RD_ARB_STATS_EN
  ,
  output logic [31:0] rd0_grant_cnt,
  output logic [31:0] rd1_grant_cnt,
  output logic [31:0] rd_stall_cnt
`endif
);

  localparam int NUM_RQ = 2;

  // ---------------- read side ----------------
  logic [NUM_RQ-1:0]               rd_val, rd_grant;
  logic [NUM_RQ-1:0][addr_w_p-1:0] rd_addr;
  logic                            rd_hs;
  logic                            prio_q, prio_d;
  logic                            owner_q, owner_d;

  assign rd_val  = {bus.rd1_req_val,  bus.rd0_req_val};
  assign rd_addr = {bus.rd1_req_addr, bus.rd0_req_addr};

  // Grant depends only on valids and prio, never on any ready, so requesters
  // see a stable grant while the RAM is backpressured.
  always_comb begin
    rd_grant    = '0;
    rd_grant[0] = rd_val[0] & (~rd_val[1] | ~prio_q);
    rd_grant[1] = rd_val[1] & (~rd_val[0] |  prio_q);
  end

  assign bus.ram_rd_req_val  = |rd_val;
  assign bus.ram_rd_req_addr = rd_addr[rd_grant[1]];
  assign rd_hs               = bus.ram_rd_req_val & bus.ram_rd_req_rdy;

  assign bus.rd0_req_rdy = rd_grant[0] & bus.ram_rd_req_rdy;
  assign bus.rd1_req_rdy = rd_grant[1] & bus.ram_rd_req_rdy;

  // The RAM drops ram_rd_req_rdy while a response is stalled, so owner
  // cannot move under an unconsumed response.
  always_comb begin
    prio_d  = prio_q;
    owner_d = owner_q;
    if (rd_hs) begin
      owner_d = rd_grant[1];
      prio_d  = ~rd_grant[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      prio_q  <= prio_d;
      owner_q <= owner_d;
    end
  end

  // Response data fans out unqualified; only the valid is steered.
  assign bus.rd0_resp_val    = bus.ram_rd_resp_val & ~owner_q;
  assign bus.rd1_resp_val    = bus.ram_rd_resp_val &  owner_q;
  assign bus.rd0_resp_data   = bus.ram_rd_resp_data;
  assign bus.rd1_resp_data   = bus.ram_rd_resp_data;
  assign bus.ram_rd_resp_rdy = owner_q ? bus.rd1_resp_rdy : bus.rd0_resp_rdy;

  // ---------------- write side ----------------
  logic [width_p-1:0]  wr_data_mux;
  logic [addr_w_p-1:0] wr_addr_mux;

  always_comb begin
    wr_addr_mux = bus.wr1_req_addr;
    wr_data_mux = bus.wr1_req_data;
    if (bus.wr0_req_val) begin
      wr_addr_mux = bus.wr0_req_addr;
      wr_data_mux = bus.wr0_req_data;
    end
  end

  assign bus.wr0_req_rdy     = bus.ram_wr_req_rdy;
  assign bus.wr1_req_rdy     = bus.ram_wr_req_rdy & ~bus.wr0_req_val;
  assign bus.ram_wr_req_val  = bus.wr0_req_val | bus.wr1_req_val;
  assign bus.ram_wr_req_addr = wr_addr_mux;
  assign bus.ram_wr_req_data = wr_data_mux;

`ifdef RAM_RD_ARB_STATS_EN
  // ---------------- statistics ----------------
  logic [31:0] gnt0_cnt_q, gnt0_cnt_d;
  logic [31:0] gnt1_cnt_q, gnt1_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    gnt0_cnt_d  = gnt0_cnt_q;
    gnt1_cnt_d  = gnt1_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (rd_hs &  rd_grant[0]) gnt0_cnt_d = gnt0_cnt_q + 32'd1;
    if (rd_hs &  rd_grant[1]) gnt1_cnt_d = gnt1_cnt_q + 32'd1;
    if (bus.ram_rd_req_val & ~bus.ram_rd_req_rdy) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0_cnt_q  <= '0;
      gnt1_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      gnt0_cnt_q  <= gnt0_cnt_d;
      gnt1_cnt_q  <= gnt1_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rd0_grant_cnt = gnt0_cnt_q;
  assign rd1_grant_cnt = gnt1_cnt_q;
  assign rd_stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ram_1r1w_rd_arbiter.sv
// tb_ram_1r1w_rd_arbiter
//   Drives the arbiter with directed and random traffic against a small
//   1-cycle-latency RAM with bypass and response hold. A transaction-level
//   model (who should win, what data each requester should get back) runs
//   alongside and every cycle is compared against it.
module tb_ram_1r1w_rd_arbiter;
  localparam int W  = 8;
  localparam int E  = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_1r1w_rd_arbiter_if #(.width_p(W), .addr_w_p(AW)) bus ();

`ifdef RAM_RD_ARB_STATS_EN
  logic [31:0] rd0_grant_cnt, rd1_grant_cnt, rd_stall_cnt;
`endif

  ram_1r1w_rd_arbiter #(.width_p(W), .els_p(E), .addr_w_p(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef RAM_RD_ARB_STATS_EN
    ,
    .rd0_grant_cnt (rd0_grant_cnt),
    .rd1_grant_cnt (rd1_grant_cnt),
    .rd_stall_cnt  (rd_stall_cnt)
`endif
  );

  // ---------------- RAM model ----------------
  logic [W-1:0] init_vals [E];
  logic [W-1:0] ram_mem   [E];
  logic         load = 1'b0;
  logic         ram_rv_q = 1'b0;
  logic [W-1:0] ram_rd_q = '0;

  assign bus.ram_rd_resp_val  = ram_rv_q;
  assign bus.ram_rd_resp_data = ram_rd_q;
  assign bus.ram_rd_req_rdy   = bus.ram_rd_resp_rdy | ~ram_rv_q;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < E; i++) ram_mem[i] <= init_vals[i];
    end else if (!rst && bus.ram_wr_req_val && bus.ram_wr_req_rdy)
      ram_mem[bus.ram_wr_req_addr] <= bus.ram_wr_req_data;
    if (rst) ram_rv_q <= 1'b0;
    else if (bus.ram_rd_req_val && bus.ram_rd_req_rdy) begin
      ram_rv_q <= 1'b1;
      ram_rd_q <= (bus.ram_wr_req_val && bus.ram_wr_req_rdy &&
                   bus.ram_wr_req_addr == bus.ram_rd_req_addr)
                  ? bus.ram_wr_req_data : ram_mem[bus.ram_rd_req_addr];
    end else if (bus.ram_rd_resp_rdy) ram_rv_q <= 1'b0;
  end

  // ---------------- stimulus variables ----------------
  logic [1:0]    v, rr, wv;
  logic [AW-1:0] a  [2];
  logic [AW-1:0] wa [2];
  logic [W-1:0]  wd [2];
  logic          wrdy;

  // ---------------- reference model ----------------
  logic [W-1:0] m_mem [E];
  int           m_prio, m_owner;
  bit           m_rv;
  logic [W-1:0] m_rdata;
  int unsigned  m_gcnt [2];
  int unsigned  m_stall;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    v = 2'b00; rr = 2'b11; wv = 2'b00; wrdy = 1'b1;
    for (int i = 0; i < 2; i++) begin a[i] = '0; wa[i] = '0; wd[i] = '0; end
  endtask

  task automatic apply();
    bus.rd0_req_val  = v[0];  bus.rd1_req_val  = v[1];
    bus.rd0_req_addr = a[0];  bus.rd1_req_addr = a[1];
    bus.rd0_resp_rdy = rr[0]; bus.rd1_resp_rdy = rr[1];
    bus.wr0_req_val  = wv[0]; bus.wr1_req_val  = wv[1];
    bus.wr0_req_addr = wa[0]; bus.wr1_req_addr = wa[1];
    bus.wr0_req_data = wd[0]; bus.wr1_req_data = wd[1];
    bus.ram_wr_req_rdy = wrdy;
  endtask

  // One cycle: drive, compare against the model, then advance the model.
  task automatic step();
    bit anyv, rrdy, whs;
    int win, wwin;
    logic [W-1:0] rdat;
    @(negedge clk);
    apply();
    #1;
    anyv = v[0] | v[1];
    win  = (v[0] && v[1]) ? m_prio : (v[1] ? 1 : 0);
    rrdy = !m_rv || rr[m_owner];
    wwin = wv[0] ? 0 : 1;
    whs  = (wv != 2'b00) && wrdy;

    chk("ram_rd_req_val", bus.ram_rd_req_val, anyv);
    if (anyv) chk("ram_rd_req_addr", bus.ram_rd_req_addr, a[win]);
    chk("rd0_req_rdy", bus.rd0_req_rdy, anyv && win == 0 && rrdy);
    chk("rd1_req_rdy", bus.rd1_req_rdy, anyv && win == 1 && rrdy);
    chk("rd0_resp_val", bus.rd0_resp_val, m_rv && m_owner == 0);
    chk("rd1_resp_val", bus.rd1_resp_val, m_rv && m_owner == 1);
    if (m_rv) chk("rd_resp_data", (m_owner == 1) ? bus.rd1_resp_data : bus.rd0_resp_data, m_rdata);
    chk("wr0_req_rdy", bus.wr0_req_rdy, wrdy);
    chk("wr1_req_rdy", bus.wr1_req_rdy, wrdy && !wv[0]);
    chk("ram_wr_req_val", bus.ram_wr_req_val, wv != 2'b00);
    if (wv != 2'b00) begin
      chk("ram_wr_req_addr", bus.ram_wr_req_addr, wa[wwin]);
      chk("ram_wr_req_data", bus.ram_wr_req_data, wd[wwin]);
    end

    if (anyv && rrdy) begin
      rdat = (whs && wa[wwin] == a[win]) ? wd[wwin] : m_mem[a[win]];
      m_rv = 1; m_owner = win; m_prio = 1 - win; m_rdata = rdat;
      m_gcnt[win]++;
    end else if (m_rv && rr[m_owner]) m_rv = 0;
    if (anyv && !rrdy) m_stall++;
    if (whs) m_mem[wa[wwin]] = wd[wwin];
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle(); apply();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_prio = 0; m_owner = 0; m_rv = 0;
    m_gcnt[0] = 0; m_gcnt[1] = 0; m_stall = 0;
  endtask

  initial begin
    idle(); apply();
    for (int i = 0; i < E; i++) init_vals[i] = W'($urandom);
    init_vals[5] = 8'hAB;
    for (int i = 0; i < E; i++) m_mem[i] = init_vals[i];
    load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    do_reset();

    // reset state
    idle(); step();

    // single read, 1-cycle latency
    idle(); v[0] = 1; a[0] = 5; step();
    idle(); step();
    chk("tp1_data", bus.rd0_resp_data, 8'hAB);

    // contention from reset: 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle(); v = 2'b11; a[0] = 1; a[1] = 2; step();
    end
    idle(); step();

    // rd1 response stalled while rd0 waits
    idle(); v[1] = 1; a[1] = 3; rr[1] = 0; step();
    for (int i = 0; i < 3; i++) begin
      idle(); v[0] = 1; a[0] = 6; rr[1] = 0; step();
    end
    idle(); v[0] = 1; a[0] = 6; step();
    idle(); step();

    // write priority
    idle(); wv = 2'b11; wa[0] = 7; wd[0] = 8'h11; wa[1] = 8; wd[1] = 8'h22; step();
    idle(); wv = 2'b10; wa[1] = 8; wd[1] = 8'h22; step();
    idle(); v[0] = 1; a[0] = 7; step();
    idle(); step();
    chk("wr_readback7", bus.rd0_resp_data, 8'h11);
    idle(); v[1] = 1; a[1] = 8; step();
    idle(); step();
    chk("wr_readback8", bus.rd1_resp_data, 8'h22);

    // same-cycle read/write bypass
    idle(); v[0] = 1; a[0] = 4; wv[1] = 1; wa[1] = 4; wd[1] = 8'h5A; step();
    idle(); step();
    chk("bypass_data", bus.rd0_resp_data, 8'h5A);

    // reset while a response is stalled drops it
    idle(); v[0] = 1; a[0] = 2; rr = 2'b00; step();
    idle(); rr = 2'b00; step();
    do_reset();
    idle(); step();

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      v    = 2'($urandom);
      rr   = 2'($urandom_range(0, 3) == 0 ? $urandom : 2'b11);
      wv   = 2'($urandom);
      wrdy = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < 2; i++) begin
        a[i]  = AW'($urandom);
        wa[i] = AW'($urandom);
        wd[i] = W'($urandom);
      end
      step();
    end

`ifdef RAM_RD_ARB_STATS_EN
    @(negedge clk); #1;
    chk("rd0_grant_cnt", rd0_grant_cnt, m_gcnt[0]);
    chk("rd1_grant_cnt", rd1_grant_cnt, m_gcnt[1]);
    chk("rd_stall_cnt",  rd_stall_cnt,  m_stall);
    do_reset();
    #1;
    chk("rd0_grant_cnt_rst", rd0_grant_cnt, 32'd0);
    chk("rd1_grant_cnt_rst", rd1_grant_cnt, 32'd0);
    chk("rd_stall_cnt_rst",  rd_stall_cnt,  32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
